// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and parity-mode constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser, falling-edge detect and 3-sample majority vote
module uart_rx_sampler #(
  parameter int OSR = 16,
  parameter int SW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          s_tick,
  input  logic [SW-1:0] s,
  output logic          rxs,
  output logic          fall,
  output logic          vote
);

  localparam logic [SW-1:0] S_EARLY = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] S_MID   = SW'(OSR / 2);

  logic sync1;
  logic rxs_d;
  logic smp_early;
  logic smp_mid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      rxs       <= 1'b0;
      rxs_d     <= 1'b0;
      smp_early <= 1'b0;
      smp_mid   <= 1'b0;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
      if (s_tick && (s == S_EARLY)) smp_early <= rxs;
      if (s_tick && (s == S_MID))   smp_mid   <= rxs;
    end
  end

  assign fall = rxs_d & ~rxs;
  // Third sample is the live value; the vote is only meaningful on tick OSR/2+1.
  assign vote = (smp_early & smp_mid) | (smp_early & rxs) | (smp_mid & rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised oversampling UART receiver with parity, framing and break status
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OSR     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      parity_mode,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  localparam int SMAX = (OSR > SB_TICK) ? OSR : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_VOTE     = SW'(OSR / 2 + 1);
  localparam logic [SW-1:0] S_BIT_END  = SW'(OSR - 1);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  uart_state_t     state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [1:0]      par_mode;
  logic            par_bit;
  logic            stop_bit;
  logic            rxs;
  logic            fall;
  logic            vote;
  logic            par_exp;
  logic            par_on;

  uart_rx_sampler #(
    .OSR (OSR),
    .SW  (SW)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .s_tick (s_tick),
    .s      (s),
    .rxs    (rxs),
    .fall   (fall),
    .vote   (vote)
  );

  assign par_on  = parity_enabled(par_mode);
  assign par_exp = (par_mode == PAR_ODD) ? ~^b : ^b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      par_mode     <= PAR_NONE;
      par_bit      <= 1'b0;
      stop_bit     <= 1'b0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (fall && !rxs) begin
            state    <= START;
            s        <= '0;
            par_mode <= parity_mode;
          end
        end
        START: begin
          if (s_tick) begin
            if ((s == S_VOTE) && vote) begin
              state <= IDLE;
              s     <= '0;
            end else if (s == S_BIT_END) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_VOTE) b <= {vote, b[DBIT-1:1]};
            if (s == S_BIT_END) begin
              s <= '0;
              if (n == N_LAST) state <= par_on ? PARITY : STOP;
              else             n     <= n + 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s == S_VOTE) par_bit <= vote;
            if (s == S_BIT_END) begin
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_VOTE) stop_bit <= vote;
            if (s == S_STOP_END) begin
              // Stop vote was captured on an earlier tick, so it is stable here.
              state        <= IDLE;
              s            <= '0;
              rx_dout      <= b;
              rx_done_tick <= 1'b1;
              parity_err   <= par_on && (par_bit != par_exp);
              frame_err    <= ~stop_bit;
              break_det    <= (b == '0) && !stop_bit && !(par_on && par_bit);
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised oversampling UART receiver, the successor to the team's fixed 8N1 receiver. It adds a configurable data width, oversampling ratio and stop length, run-time parity selection, a 3-sample majority vote, false-start rejection, and parity, framing and break status. It sits between the baud-tick generator (`s_tick`) and the RX FIFO / register interface, in the same position as the current receiver.

## Interface
- `DBIT`, default 8: data bits per frame, legal range 5–9.
- `OSR`, default 16: `s_tick` pulses per bit; even, ≥ 8.
- `SB_TICK`, default 16: stop-bit length in ticks; `OSR` = 1 stop, `1.5*OSR` = 1.5, `2*OSR` = 2.
- `clk`  in  1  system clock; every flop is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line, asynchronous, idles high.
- `s_tick`  in  1  oversample enable, one `clk` wide.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none; captured at start detect.
- `rx_dout`  out  DBIT  received word, LSB first on the line, registered.
- `rx_done_tick`  out  1  one-cycle frame-complete strobe.
- `parity_err`  out  1  parity mismatch on the last frame.
- `frame_err`  out  1  stop bit sampled low on the last frame.
- `break_det`  out  1  last frame was all-zero: data, parity if enabled, and stop.

## Operation
- `rx` passes through a 2-FF synchroniser, then a third flop for edge detection. All decisions use the synchronised value `rxs`.
- Tick counter `s` is `$clog2(max(OSR,SB_TICK))` bits. Bit counter `n` is `$clog2(DBIT)` bits. Shift register is DBIT bits.
- Majority vote per bit: sample `rxs` on ticks `s = OSR/2-1`, `OSR/2`, `OSR/2+1`. The bit value is 2-of-3, decided on tick `OSR/2+1`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START on a falling edge of `rxs` (previous 1, current 0). Clear `s`, latch `parity_mode`. A continuously low line never starts a frame.
- START, per tick `s++`:
  - vote = 1 → false start; go to IDLE with no strobe and no flag change.
  - vote = 0 and `s == OSR-1` → DATA with `s = 0`, `n = 0`.
- DATA: shift the vote into the MSB (`b = {vote, b[DBIT-1:1]}`) at the decision tick.
  - At `s == OSR-1`: if `n == DBIT-1`, go to PARITY (parity enabled) or STOP; else `n++`, `s = 0`.
- PARITY: compute the vote. Expected value is `^b` for even mode and `~^b` for odd mode. At `s == OSR-1` → STOP.
- STOP: the vote at the decision tick is the stop value. At `s == SB_TICK-1` → IDLE and the frame completes.
- Frame complete: `rx_dout`, `parity_err`, `frame_err` and `break_det` load together with `rx_done_tick = 1`.
- Reset values: all outputs 0, state IDLE, counters 0, shift register 0.

## Timing
- `rx_done_tick` is high for exactly one `clk`: the cycle after the `s_tick` edge on which STOP reaches `s == SB_TICK-1`.
- `rx_dout` and the three flags update on that same edge and hold until the next completed frame. False starts and reset are the only other events that can change them, and false starts do not.
- Latency from the line falling edge to `rx_done_tick` is (1 + DBIT + P)·OSR + SB_TICK ticks, plus 3 `clk` of synchroniser delay. P is 1 when parity is enabled, else 0.
- A change to `parity_mode` during a frame takes effect at the next start.
- No overrun detection. The consumer takes `rx_dout` on the strobe.
- `s_tick` held low freezes the FSM in place. Back-to-back frames are accepted as soon as IDLE sees a falling edge.
- Reset asserted mid-frame aborts the frame with no strobe and returns everything to reset values asynchronously.
- `frame_err`, `parity_err` and `break_det` may be set together. `break_det` implies `frame_err`.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (shared with the future TX);
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
- Sub-module `uart_rx_sampler` holds the synchroniser, edge detect and 3-sample majority vote. Its inputs are `clk`, `rst`, `rx`, `s_tick` and `s`. Its outputs are `rxs`, `fall` and `vote`.
- The top level holds the FSM, counters, shift register and status registers.

## Test plan
- 8N1 default, frame 0xA5 with a clean line → `rx_dout = 8'hA5`, one-cycle `rx_done_tick`, all flags 0, done 160 ticks + 3 clk after the falling edge.
- DBIT=7, even parity, data 0x41 with parity bit 1 (wrong; correct is 0) → `rx_dout = 7'h41`, `parity_err = 1`. Repeat with the correct bit → `parity_err = 0`.
- Glitch: `rx` low for 3 ticks then high → no `rx_done_tick`, outputs unchanged, FSM back in IDLE. A following valid 0x3C frame is received correctly.
- Single-tick inversion at `s = OSR/2` inside data bit 3 of 0xFF → majority still gives `rx_dout = 8'hFF`.
- Line held low for 2 frame times → exactly one strobe with `rx_dout = 0`, `frame_err = 1`, `break_det = 1`. No further strobe until the line returns high and a new falling edge occurs.
- `rst` pulsed at mid-data of a frame → outputs 0 immediately, no strobe. The next full frame 0x5A is received correctly.
